// File: rtl/cpu_pkg.sv
// Shared sequencer definitions: state encodings seen by the decoder and the retirement counter width.
package cpu_pkg;
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC1 = 2'b01,
        ST_EXEC2 = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam int RETIRED_W = 16;
endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: enable-driven increment, async clear, natural wrap at full scale.
module retire_counter
    import cpu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    output logic [RETIRED_W-1:0] count
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer FSM (FETCH/EXEC1/EXEC2/HALT) with retirement count and PC-redirect flag.
// Define CPU_SINGLE_STEP_EN to build in single-step pausing; otherwise paused/step_ack stay 0.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sm_extra,
    input  logic                 stop,
    input  logic                 set_jump,
    input  logic                 mul_busy,
    input  logic                 resume,
    input  logic                 step_mode,
    input  logic                 step_req,
    output logic [1:0]           state,
    output logic                 jump,
    output logic                 halted,
    output logic                 paused,
    output logic                 step_ack,
    output logic [RETIRED_W-1:0] retired
);
    state_t st;
    logic   retire;
    logic   step_hold;
    logic   step_go;

    // stop in EXEC1 sends the instruction to HALT without retiring it
    assign retire = (st == ST_EXEC1 && !stop && !sm_extra) ||
                    (st == ST_EXEC2 && !mul_busy);

`ifdef CPU_SINGLE_STEP_EN
    assign step_hold = retire & step_mode;
    assign step_go   = paused & step_req;
`else
    logic unused_step;
    assign unused_step = &{1'b0, step_mode, step_req};
    assign step_hold   = 1'b0;
    assign step_go     = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st       <= ST_FETCH;
            jump     <= 1'b0;
            halted   <= 1'b0;
            paused   <= 1'b0;
            step_ack <= 1'b0;
        end else begin
            step_ack <= step_hold;
            case (st)
                ST_FETCH: st <= ST_EXEC1;
                ST_EXEC1: begin
                    jump <= set_jump;
                    if (stop) begin
                        st     <= ST_HALT;
                        halted <= 1'b1;
                    end else if (sm_extra) begin
                        st <= ST_EXEC2;
                    end else if (step_hold) begin
                        st     <= ST_HALT;
                        paused <= 1'b1;
                    end else begin
                        st <= ST_FETCH;
                    end
                end
                ST_EXEC2: begin
                    if (!mul_busy) begin
                        jump <= set_jump;
                        if (step_hold) begin
                            st     <= ST_HALT;
                            paused <= 1'b1;
                        end else begin
                            st <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    // step_go is gated by paused, so a stop-halt ignores step_req
                    if (resume || step_go) begin
                        st     <= ST_FETCH;
                        halted <= 1'b0;
                        paused <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign state = st;

    retire_counter u_retire (
        .clock (clock),
        .reset (reset),
        .en    (retire),
        .count (retired)
    );
endmodule
